// File: rtl/button_debouncer.sv
// Pushbutton debouncer: 2-FF synchroniser feeding a stability-qualifying FSM.
// Produces a clean active-low level plus a busy flag while a change is pending.
`timescale 1ns/1ps
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 250000,
    parameter int unsigned CNT_W         = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic long_pulse,
    output logic busy
);

    localparam logic [1:0] ST_RELEASED  = 2'b00;
    localparam logic [1:0] ST_WAIT_LOW  = 2'b01;
    localparam logic [1:0] ST_PRESSED   = 2'b10;
    localparam logic [1:0] ST_WAIT_HIGH = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (!s2_q) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (s2_q) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (s2_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs straight from the state register: no path from btn_raw.
    assign long_pulse = (state_q == ST_RELEASED) || (state_q == ST_WAIT_LOW);
    assign busy       = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH);

endmodule
